booth_mult: RTL

BOOTH_MULT -- requirements
Module: booth_mult

---
 rtl/booth_mult.sv | 112 +++++++++++
 1 files changed

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift step per clock,
// handling both two's-complement and unsigned operands via a one-bit extension.
module booth_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = $clog2(W1 + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [W1-1:0]      r_acc;
    logic [W1-1:0]      r_q;
    logic [W1-1:0]      r_m;
    logic               r_qm1;
    logic [CW-1:0]      r_cnt;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;
    logic [W1-1:0]      w_sum;
    logic [W1-1:0]      w_aExt;
    logic [W1-1:0]      w_bExt;

    // The extra top bit lets unsigned operands ride through the signed Booth recoding.
    assign w_aExt = {signed_mode & a[WIDTH-1], a};
    assign w_bExt = {signed_mode & b[WIDTH-1], b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (r_cnt == CW'(1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    always_comb begin
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m   <= w_aExt;
                        r_q   <= w_bExt;
                        r_acc <= '0;
                        r_qm1 <= 1'b0;
                        r_cnt <= CW'(W1);
                    end
                end
                RUN: begin
                    r_acc <= {w_sum[W1-1], w_sum[W1-1:1]};
                    r_q   <= {w_sum[0], r_q[W1-1:1]};
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt - CW'(1);
                end
                DONE: begin
                    // Low 2*WIDTH bits of {acc,q}; the top two bits are only sign copies.
                    r_product <= {r_acc[WIDTH-2:0], r_q};
                end
                default: ;
            endcase
        end
    end

    assign done    = r_done;
    assign product = r_product;

endmodule
